// File: rtl/tetris_pkg.sv
// Shared shape ids, bag FSM states and the 7-bag pick helper.
// Pure declarations and combinational functions, so it adds no latency and applies no backpressure.
package tetris_pkg;

  localparam int NUM_SHAPES = 7;
  localparam int SHAPE_W    = 3;

  localparam logic [SHAPE_W-1:0] SHAPE_O = 3'd0;
  localparam logic [SHAPE_W-1:0] SHAPE_I = 3'd1;
  localparam logic [SHAPE_W-1:0] SHAPE_T = 3'd2;
  localparam logic [SHAPE_W-1:0] SHAPE_L = 3'd3;
  localparam logic [SHAPE_W-1:0] SHAPE_J = 3'd4;
  localparam logic [SHAPE_W-1:0] SHAPE_S = 3'd5;
  localparam logic [SHAPE_W-1:0] SHAPE_Z = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL_CUR,
    ST_FILL_NXT,
    ST_READY
  } bag_state_e;

  // Candidate comes from the low three LFSR bits; 7 folds onto 0. The scan then
  // wraps mod 7 until it finds an id that has not been drawn from this bag.
  function automatic logic [SHAPE_W-1:0] bag_pick(input logic [15:0] lfsr_w,
                                                 input logic [NUM_SHAPES-1:0] mask);
    logic [SHAPE_W-1:0] cand;
    logic [3:0]         sum;
    logic [SHAPE_W-1:0] idx;
    logic               found;
    cand     = (lfsr_w[2:0] == 3'd7) ? 3'd0 : lfsr_w[2:0];
    bag_pick = cand;
    found    = 1'b0;
    for (int k = 0; k < NUM_SHAPES; k++) begin
      sum = {1'b0, cand} + 4'(k);
      idx = (sum >= 4'd7) ? 3'(sum - 4'd7) : sum[2:0];
      if (!found && !mask[idx]) begin
        bag_pick = idx;
        found    = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/tetris_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11); a zero seed is replaced by 1.
// Output is the register itself, advancing every cycle out of reset; no handshake, never stalls.
module tetris_lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] lfsr
);

  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  always_comb begin
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= SEED_EFF;
    else        lfsr_q <= lfsr_d;
  end

  assign lfsr = lfsr_q;

endmodule

// File: rtl/shape_bag_generator.sv
// 7-bag shape generator: current + one-deep preview; start->shape_valid in 3 edges, req advances next cycle.
// req is only honoured in READY and never stalls; optional hold slot is built when SHAPE_HOLD_EN is defined.
module shape_bag_generator
  import tetris_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       req,
  output logic [2:0] shape_id,
  output logic       shape_valid,
  output logic [2:0] next_shape_id,
  output logic [2:0] bag_remaining
`ifdef SHAPE_HOLD_EN
  ,
  input  logic       hold_req,
  output logic [2:0] hold_id,
  output logic       hold_valid
`endif
);

  logic [15:0] lfsr;

  tetris_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .lfsr  (lfsr)
  );

  bag_state_e            state_q, state_d;
  logic [NUM_SHAPES-1:0] mask_q, mask_d;
  logic [SHAPE_W-1:0]    shape_q, shape_d;
  logic [SHAPE_W-1:0]    nxt_q, nxt_d;
  logic                  valid_q, valid_d;

  logic [SHAPE_W-1:0]    pick;
  logic [NUM_SHAPES-1:0] mask_pick;
  logic [NUM_SHAPES-1:0] mask_after;

`ifdef SHAPE_HOLD_EN
  logic [SHAPE_W-1:0] hold_q, hold_d;
  logic               hold_vld_q, hold_vld_d;
  logic               hold_lock_q, hold_lock_d;
`endif

  // A full mask means the bag just emptied, so the next pick starts a fresh bag.
  always_comb begin
    pick       = bag_pick(lfsr, mask_q);
    mask_pick  = mask_q | (7'd1 << pick);
    mask_after = (mask_pick == 7'h7F) ? 7'd0 : mask_pick;
  end

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    shape_d = shape_q;
    nxt_d   = nxt_q;
    valid_d = valid_q;
`ifdef SHAPE_HOLD_EN
    hold_d      = hold_q;
    hold_vld_d  = hold_vld_q;
    hold_lock_d = hold_lock_q;
`endif
    if (start) begin
      state_d = ST_FILL_CUR;
      mask_d  = '0;
      valid_d = 1'b0;
`ifdef SHAPE_HOLD_EN
      hold_vld_d  = 1'b0;
      hold_lock_d = 1'b0;
`endif
    end else begin
      case (state_q)
        ST_FILL_CUR: begin
          shape_d = pick;
          mask_d  = mask_after;
          state_d = ST_FILL_NXT;
        end
        ST_FILL_NXT: begin
          nxt_d   = pick;
          mask_d  = mask_after;
          valid_d = 1'b1;
          state_d = ST_READY;
        end
        ST_READY: begin
          if (req) begin
            shape_d = nxt_q;
            nxt_d   = pick;
            mask_d  = mask_after;
`ifdef SHAPE_HOLD_EN
            hold_lock_d = 1'b0;
          end else if (hold_req && !hold_lock_q) begin
            hold_lock_d = 1'b1;
            if (!hold_vld_q) begin
              hold_d     = shape_q;
              hold_vld_d = 1'b1;
              shape_d    = nxt_q;
              nxt_d      = pick;
              mask_d     = mask_after;
            end else begin
              // Swap leaves preview and bag untouched.
              hold_d  = shape_q;
              shape_d = hold_q;
            end
`endif
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      mask_q  <= '0;
      shape_q <= SHAPE_O;
      nxt_q   <= SHAPE_O;
      valid_q <= 1'b0;
`ifdef SHAPE_HOLD_EN
      hold_q      <= SHAPE_O;
      hold_vld_q  <= 1'b0;
      hold_lock_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      shape_q <= shape_d;
      nxt_q   <= nxt_d;
      valid_q <= valid_d;
`ifdef SHAPE_HOLD_EN
      hold_q      <= hold_d;
      hold_vld_q  <= hold_vld_d;
      hold_lock_q <= hold_lock_d;
`endif
    end
  end

  assign shape_id      = shape_q;
  assign shape_valid   = valid_q;
  assign next_shape_id = nxt_q;
  assign bag_remaining = 3'(NUM_SHAPES - $countones(mask_q));
`ifdef SHAPE_HOLD_EN
  assign hold_id    = hold_q;
  assign hold_valid = hold_vld_q;
`endif

endmodule
